// File: rtl/ireg_wb_ctrl.sv
// Writeback arbiter and scoreboard for the integer register file.
// ALU has fixed priority; LSU and MDU share the write port round-robin.
module ireg_wb_ctrl #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            iss_v,
  input  logic [4:0]      iss_rs1,
  input  logic            iss_rs1_use,
  input  logic [4:0]      iss_rs2,
  input  logic            iss_rs2_use,
  input  logic [4:0]      iss_rd,
  input  logic            iss_rd_v,
  output logic            iss_stall,
  input  logic            alu_v,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_v,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  input  logic            mdu_v,
  input  logic [4:0]      mdu_rd,
  input  logic [XLEN-1:0] mdu_data,
  output logic            mdu_ready,
  output logic            rd_v,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] rd_data,
  output logic [NREG-1:0] busy
);

  typedef enum logic {
    RR_LSU = 1'b0,
    RR_MDU = 1'b1
  } rr_e;

  rr_e             rr_q, rr_d;
  logic            win_v;
  logic [4:0]      win_rd;
  logic [XLEN-1:0] win_data;
  logic            iss_fire;
  logic            haz_rs1, haz_rs2, haz_rd;
  logic [NREG-1:0] set_mask, clr_mask, busy_d;

  // A pending write hides behind the register file's same-cycle bypass.
  function automatic logic hazard(input logic [4:0] r,
                                  input logic [NREG-1:0] b,
                                  input logic wv,
                                  input logic [4:0] wr);
    return (r != 5'd0) && b[r] && !(wv && (wr == r));
  endfunction

  always_comb begin
    win_v     = 1'b0;
    win_rd    = 5'd0;
    win_data  = '0;
    lsu_ready = 1'b0;
    mdu_ready = 1'b0;
    rr_d      = rr_q;
    if (alu_v) begin
      win_v    = 1'b1;
      win_rd   = alu_rd;
      win_data = alu_data;
    end else if (lsu_v && (!mdu_v || rr_q == RR_LSU)) begin
      win_v     = 1'b1;
      win_rd    = lsu_rd;
      win_data  = lsu_data;
      lsu_ready = 1'b1;
      if (mdu_v) rr_d = RR_MDU;
    end else if (mdu_v) begin
      win_v     = 1'b1;
      win_rd    = mdu_rd;
      win_data  = mdu_data;
      mdu_ready = 1'b1;
      if (lsu_v) rr_d = RR_LSU;
    end
  end

  always_comb begin
    haz_rs1   = iss_rs1_use && hazard(iss_rs1, busy, rd_v, rd);
    haz_rs2   = iss_rs2_use && hazard(iss_rs2, busy, rd_v, rd);
    haz_rd    = iss_rd_v && hazard(iss_rd, busy, rd_v, rd);
    iss_stall = iss_v && (haz_rs1 || haz_rs2 || haz_rd);
    iss_fire  = iss_v && !iss_stall;
    set_mask  = '0;
    clr_mask  = '0;
    if (rd_v) clr_mask[rd] = 1'b1;
    if (iss_fire && iss_rd_v && (iss_rd != 5'd0)) set_mask[iss_rd] = 1'b1;
    // Set is applied after clear so a re-issue to a committing register stays busy.
    busy_d    = (busy & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_v    <= 1'b0;
      rd      <= 5'd0;
      rd_data <= '0;
      busy    <= '0;
      rr_q    <= RR_LSU;
    end else begin
      rd_v <= win_v && (win_rd != 5'd0);
      if (win_v && (win_rd != 5'd0)) begin
        rd      <= win_rd;
        rd_data <= win_data;
      end
      busy <= busy_d;
      rr_q <= rr_d;
    end
  end

endmodule

// File: tb/tb_ireg_wb_ctrl.sv
// Self-checking bench for ireg_wb_ctrl: directed scenarios plus randomized
// traffic compared every cycle against a rule-level reference model.
module tb_ireg_wb_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        iss_v, iss_rs1_use, iss_rs2_use, iss_rd_v;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd;
  logic        iss_stall;
  logic        alu_v, lsu_v, mdu_v;
  logic [4:0]  alu_rd, lsu_rd, mdu_rd;
  logic [31:0] alu_data, lsu_data, mdu_data;
  logic        lsu_ready, mdu_ready;
  logic        rd_v;
  logic [4:0]  rd;
  logic [31:0] rd_data;
  logic [31:0] busy;

  always #5 clk = ~clk;

  ireg_wb_ctrl #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .reset(reset),
    .iss_v(iss_v), .iss_rs1(iss_rs1), .iss_rs1_use(iss_rs1_use),
    .iss_rs2(iss_rs2), .iss_rs2_use(iss_rs2_use),
    .iss_rd(iss_rd), .iss_rd_v(iss_rd_v), .iss_stall(iss_stall),
    .alu_v(alu_v), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_v(lsu_v), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .mdu_v(mdu_v), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .rd_v(rd_v), .rd(rd), .rd_data(rd_data), .busy(busy)
  );

  // Reference model: set of pending registers, last committed write, RR owner.
  bit [31:0] m_busy;
  bit        m_rdv;
  bit [4:0]  m_rd;
  bit [31:0] m_rddata;
  int        m_ptr;
  int        last_w;

  bit        s_stall, s_lsu_ready, s_mdu_ready, s_rd_v;
  bit [4:0]  s_rd;
  bit [31:0] s_rd_data;

  int n_vec = 0;
  int n_cmp = 0;
  int n_err = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit hazard(input logic [4:0] r);
    return (r != 5'd0) && m_busy[r] && !(m_rdv && (m_rd == r));
  endfunction

  // 0 none, 1 ALU, 2 LSU, 3 MDU
  function automatic int winner();
    if (alu_v) return 1;
    if (lsu_v && mdu_v) return (m_ptr == 0) ? 2 : 3;
    if (lsu_v) return 2;
    if (mdu_v) return 3;
    return 0;
  endfunction

  task automatic checkOutput(input bit exp_stall, input int w);
    s_stall     = iss_stall;
    s_lsu_ready = lsu_ready;
    s_mdu_ready = mdu_ready;
    s_rd_v      = rd_v;
    s_rd        = rd;
    s_rd_data   = rd_data;
    cmp("rd_v", {31'd0, rd_v}, {31'd0, m_rdv});
    cmp("rd", {27'd0, rd}, {27'd0, m_rd});
    cmp("rd_data", rd_data, m_rddata);
    cmp("busy", busy, m_busy);
    if (!reset) begin
      cmp("iss_stall", {31'd0, iss_stall}, {31'd0, exp_stall});
      cmp("lsu_ready", {31'd0, lsu_ready}, (w == 2) ? 32'd1 : 32'd0);
      cmp("mdu_ready", {31'd0, mdu_ready}, (w == 3) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic applyStimulus();
    bit        exp_stall;
    int        w;
    bit [31:0] nb;
    bit        nrv;
    bit [4:0]  nrd, wrd;
    bit [31:0] nd, wdata;
    int        np;
    @(negedge clk);
    n_vec++;
    exp_stall = iss_v && ((iss_rs1_use && hazard(iss_rs1)) ||
                          (iss_rs2_use && hazard(iss_rs2)) ||
                          (iss_rd_v && hazard(iss_rd)));
    w = winner();
    checkOutput(exp_stall, w);
    nb = m_busy; nrv = 1'b0; nrd = m_rd; nd = m_rddata; np = m_ptr;
    if (reset) begin
      nb = 0; nrd = 0; nd = 0; np = 0;
    end else begin
      if (m_rdv) nb[m_rd] = 1'b0;
      if (iss_v && !exp_stall && iss_rd_v && iss_rd != 0) nb[iss_rd] = 1'b1;
      case (w)
        1: begin wrd = alu_rd; wdata = alu_data; end
        2: begin wrd = lsu_rd; wdata = lsu_data; end
        3: begin wrd = mdu_rd; wdata = mdu_data; end
        default: begin wrd = 0; wdata = 0; end
      endcase
      if (w != 0 && wrd != 0) begin
        nrv = 1'b1; nrd = wrd; nd = wdata;
      end
      if (!alu_v && lsu_v && mdu_v) np = 1 - m_ptr;
    end
    last_w = reset ? 0 : w;
    @(posedge clk);
    m_busy = nb; m_rdv = nrv; m_rd = nrd; m_rddata = nd; m_ptr = np;
    #1;
  endtask

  task automatic setIdle();
    iss_v = 0; iss_rs1 = 0; iss_rs1_use = 0; iss_rs2 = 0; iss_rs2_use = 0;
    iss_rd = 0; iss_rd_v = 0;
    alu_v = 0; alu_rd = 0; alu_data = 0;
    lsu_v = 0; lsu_rd = 0; lsu_data = 0;
    mdu_v = 0; mdu_rd = 0; mdu_data = 0;
  endtask

  initial begin
    m_busy = 0; m_rdv = 0; m_rd = 0; m_rddata = 0; m_ptr = 0; last_w = 0;
    setIdle();
    reset = 1;
    applyStimulus();
    applyStimulus();
    reset = 0;
    cmp("reset busy", busy, 32'd0);
    cmp("reset rd_v", {31'd0, rd_v}, 32'd0);

    // ALU pre-empts a waiting load
    alu_v = 1; alu_rd = 5; alu_data = 32'h1234;
    lsu_v = 1; lsu_rd = 9; lsu_data = 32'hAA;
    applyStimulus();
    cmp("alu lsu_ready", {31'd0, s_lsu_ready}, 32'd0);
    alu_v = 0;
    applyStimulus();
    cmp("alu rd_v", {31'd0, s_rd_v}, 32'd1);
    cmp("alu rd", {27'd0, s_rd}, 32'd5);
    cmp("alu rd_data", s_rd_data, 32'h1234);
    cmp("lone lsu ready", {31'd0, s_lsu_ready}, 32'd1);
    lsu_v = 0;

    // Contested LSU/MDU alternate
    lsu_v = 1; lsu_rd = 6; lsu_data = 32'h66;
    mdu_v = 1; mdu_rd = 7; mdu_data = 32'h77;
    applyStimulus();
    cmp("rr1 lsu_ready", {31'd0, s_lsu_ready}, 32'd1);
    cmp("rr1 mdu_ready", {31'd0, s_mdu_ready}, 32'd0);
    lsu_rd = 10; lsu_data = 32'h1010;
    applyStimulus();
    cmp("rr2 mdu_ready", {31'd0, s_mdu_ready}, 32'd1);
    cmp("rr2 lsu_ready", {31'd0, s_lsu_ready}, 32'd0);
    cmp("rr2 rd", {27'd0, s_rd}, 32'd6);
    mdu_v = 0;
    applyStimulus();
    cmp("rr3 lsu_ready", {31'd0, s_lsu_ready}, 32'd1);
    cmp("rr3 rd", {27'd0, s_rd}, 32'd7);
    lsu_rd = 11; lsu_data = 32'h11;
    mdu_v = 1; mdu_rd = 12; mdu_data = 32'h12;
    applyStimulus();
    cmp("rr4 lsu_ready", {31'd0, s_lsu_ready}, 32'd1);
    cmp("rr4 rd", {27'd0, s_rd}, 32'd10);
    lsu_v = 0;
    applyStimulus();
    mdu_v = 0;
    applyStimulus();

    // RAW on x3 released by its own commit
    iss_v = 1; iss_rd = 3; iss_rd_v = 1;
    applyStimulus();
    cmp("busy3 set", {31'd0, busy[3]}, 32'd1);
    cmp("model busy3", {31'd0, m_busy[3]}, 32'd1);
    iss_rd_v = 0; iss_rd = 0; iss_rs1 = 3; iss_rs1_use = 1;
    applyStimulus();
    cmp("raw stall a", {31'd0, s_stall}, 32'd1);
    applyStimulus();
    cmp("raw stall b", {31'd0, s_stall}, 32'd1);
    alu_v = 1; alu_rd = 3; alu_data = 32'h33;
    applyStimulus();
    cmp("raw stall c", {31'd0, s_stall}, 32'd1);
    alu_v = 0;
    applyStimulus();
    cmp("raw bypass", {31'd0, s_stall}, 32'd0);
    cmp("raw commit rd", {27'd0, s_rd}, 32'd3);
    cmp("busy3 clear", {31'd0, busy[3]}, 32'd0);
    setIdle();

    // WAW on x8, set wins over the same-cycle clear
    iss_v = 1; iss_rd = 8; iss_rd_v = 1;
    applyStimulus();
    cmp("busy8 set", {31'd0, busy[8]}, 32'd1);
    applyStimulus();
    cmp("waw stall", {31'd0, s_stall}, 32'd1);
    alu_v = 1; alu_rd = 8; alu_data = 32'h88;
    applyStimulus();
    alu_v = 0;
    applyStimulus();
    cmp("waw release", {31'd0, s_stall}, 32'd0);
    cmp("busy8 kept", {31'd0, busy[8]}, 32'd1);
    iss_v = 0;
    alu_v = 1; alu_rd = 8; alu_data = 32'h89;
    applyStimulus();

    // Write to x0 is accepted but dropped; x0 never stalls
    alu_v = 0;
    lsu_v = 1; lsu_rd = 0; lsu_data = 32'hDEAD;
    iss_v = 1; iss_rs1 = 0; iss_rs1_use = 1; iss_rs2 = 0; iss_rs2_use = 1;
    iss_rd = 0; iss_rd_v = 1;
    applyStimulus();
    cmp("x0 lsu_ready", {31'd0, s_lsu_ready}, 32'd1);
    cmp("x0 no stall", {31'd0, s_stall}, 32'd0);
    setIdle();
    applyStimulus();
    cmp("x0 rd_v", {31'd0, s_rd_v}, 32'd0);
    cmp("x0 rd held", {27'd0, s_rd}, 32'd8);
    cmp("x0 data held", s_rd_data, 32'h89);

    // Reset mid-operation
    for (int r = 4; r < 8; r++) begin
      iss_v = 1; iss_rd = 5'(r); iss_rd_v = 1;
      if (r == 7) begin alu_v = 1; alu_rd = 9; alu_data = 32'h99; end
      applyStimulus();
    end
    setIdle();
    cmp("pre-reset busy", busy, 32'h0000_00F0);
    cmp("pre-reset rd_v", {31'd0, rd_v}, 32'd1);
    reset = 1;
    applyStimulus();
    reset = 0;
    cmp("post-reset busy", busy, 32'd0);
    cmp("post-reset rd_v", {31'd0, rd_v}, 32'd0);

    // Randomized traffic; losers hold their request until granted
    last_w = 0;
    for (int i = 0; i < 600; i++) begin
      if (last_w == 2) lsu_v = 0;
      if (last_w == 3) mdu_v = 0;
      if (!lsu_v && $urandom_range(0, 9) < 4) begin
        lsu_v = 1; lsu_rd = 5'($urandom_range(0, 7)); lsu_data = $urandom;
      end
      if (!mdu_v && $urandom_range(0, 9) < 4) begin
        mdu_v = 1; mdu_rd = 5'($urandom_range(0, 7)); mdu_data = $urandom;
      end
      alu_v = ($urandom_range(0, 3) == 0);
      alu_rd = 5'($urandom_range(0, 7)); alu_data = $urandom;
      iss_v = ($urandom_range(0, 9) < 6);
      iss_rs1 = 5'($urandom_range(0, 7)); iss_rs1_use = 1'($urandom_range(0, 1));
      iss_rs2 = 5'($urandom_range(0, 7)); iss_rs2_use = 1'($urandom_range(0, 1));
      iss_rd = 5'($urandom_range(0, 7)); iss_rd_v = 1'($urandom_range(0, 1));
      reset = (i == 300);
      if (reset) begin lsu_v = 0; mdu_v = 0; end
      applyStimulus();
    end
    reset = 0;
    setIdle();
    applyStimulus();

    $display("[TB] %0d comparisons made", n_cmp);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
